dmem_responder: RTL

- Data-memory target for the core's load/store port: the responder end of the datapath's Address/WriteData/MemRW/ReadData path.
- Adds a valid/ready request channel, a fixed wait-state pipeline and a response channel with backpressure.
- Supports byte, half and word accesses with sign/zero extension, misalignment and out-of-range error reporting.
- Sits between the datapath's memory stage and the word-organised data storage; the storage array is internal to this block.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Request/response channel between the datapath memory stage and the data-memory responder.
// The initiator drives the request fields and resp_ready; the responder drives the rest.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed wait states, held response.
// Byte/half/word accesses with extension; misaligned, reserved-size and out-of-range faults.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);

    localparam int unsigned IdxW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] LimitBytes = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LatCnt     = 4'(LATENCY);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q, write_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        capture;
    logic        commit;
    logic        req_ready_c;
    logic        resp_valid_c;

    logic [31:0] acc_addr, acc_wdata;
    logic [1:0]  acc_size;
    logic        acc_unsigned, acc_write;

    logic [31:0] off;
    logic [1:0]  lane;
    logic [IdxW-1:0] idx;
    logic        acc_err;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd_word, shifted, load_data;
    logic        mem_we;

    logic [31:0] mem [DEPTH_WORDS];

    // With zero latency the access commits on the accepting edge, so decode the live request.
    always_comb begin
        if (state_q == StIdle) begin
            acc_addr     = bus.req_addr;
            acc_wdata    = bus.req_wdata;
            acc_size     = bus.req_size;
            acc_unsigned = bus.req_unsigned;
            acc_write    = bus.req_write;
        end else begin
            acc_addr     = addr_q;
            acc_wdata    = wdata_q;
            acc_size     = size_q;
            acc_unsigned = unsigned_q;
            acc_write    = write_q;
        end
    end

    assign off  = acc_addr - ADDR_BASE;
    assign lane = off[1:0];
    assign idx  = off[IdxW+1:2];

    always_comb begin
        acc_err = 1'b0;
        if (off >= LimitBytes) begin
            acc_err = 1'b1;
        end
        unique case (acc_size)
            2'b00:   ;
            2'b01:   if (lane[0]) acc_err = 1'b1;
            2'b10:   if (lane != 2'b00) acc_err = 1'b1;
            default: acc_err = 1'b1;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the addressed ones.
    always_comb begin
        be = 4'b0000;
        wd = 32'h0;
        unique case (acc_size)
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be = 4'b0011 << lane;
                wd = {2{acc_wdata[15:0]}};
            end
            2'b10: begin
                be = 4'b1111;
                wd = acc_wdata;
            end
            default: ;
        endcase
    end

    assign rd_word = mem[idx];
    assign shifted = rd_word >> {lane, 3'b000};

    always_comb begin
        unique case (acc_size)
            2'b00:   load_data = acc_unsigned ? {24'h0, shifted[7:0]}
                                              : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = acc_unsigned ? {16'h0, shifted[15:0]}
                                              : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        capture      = 1'b0;
        commit       = 1'b0;
        req_ready_c  = 1'b0;
        resp_valid_c = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    capture = 1'b1;
                    cnt_d   = LatCnt;
                    if (LatCnt == 4'd0) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                end
            end
            StResp: begin
                resp_valid_c = 1'b1;
                if (bus.resp_ready) begin
                    state_d = StIdle;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (commit) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_write) ? 32'h0 : load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (capture) begin
                addr_q     <= bus.req_addr;
                wdata_q    <= bus.req_wdata;
                size_q     <= bus.req_size;
                unsigned_q <= bus.req_unsigned;
                write_q    <= bus.req_write;
            end
        end
    end

    // Storage is not reset; gating with reset drops a store that has not yet committed.
    assign mem_we = commit && acc_write && !acc_err && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // A presented response must not change until the initiator takes it.
    assert property (@(posedge clk) disable iff (reset)
        (state_q == StResp && !bus.resp_ready)
            |=> (state_q == StResp && $stable(rdata_q) && $stable(err_q)));

endmodule
